// File: rtl/mac_pipe_if.sv
// rtl/mac_pipe_if.sv - operand/result bundle for the pipelined multiply-accumulate unit
interface mac_pipe_if #(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int ACC_W = 16
);
    // operand side
    logic             in_valid;
    logic [A_W-1:0]   a;
    logic [B_W-1:0]   b;
    logic [ACC_W-1:0] c;
    logic             mode;
    logic             clr;

    // result side
    logic             out_valid;
    logic [ACC_W-1:0] d;
    logic             ovf;
    logic             ovf_sticky;
    logic [ACC_W-1:0] acc;

    // operand source / result consumer
    modport master (
        output in_valid, a, b, c, mode, clr,
        input  out_valid, d, ovf, ovf_sticky, acc
    );

    // the mac_pipe datapath
    modport slave (
        input  in_valid, a, b, c, mode, clr,
        output out_valid, d, ovf, ovf_sticky, acc
    );
endinterface

// File: rtl/mac_pipe.sv
// rtl/mac_pipe.sv - two-stage unsigned multiply-add / multiply-accumulate with overflow detect
module mac_pipe #(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int ACC_W = 16,
    parameter int SAT   = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    mac_pipe_if.slave     bus
);
    localparam int P_W  = A_W + B_W;
    // one extra bit above the wider of product and accumulator catches the carry
    localparam int S_W  = ((P_W > ACC_W) ? P_W : ACC_W) + 1;

    // stage 1 registers
    logic [P_W-1:0]   p1;
    logic [ACC_W-1:0] c1;
    logic             mode1;
    logic             v1;

    // stage 2 / output registers
    logic             out_valid_q;
    logic [ACC_W-1:0] d_q;
    logic             ovf_q;
    logic             ovf_sticky_q;
    logic [ACC_W-1:0] acc_q;

    // stage 2 combinational results
    logic [ACC_W-1:0] addend;
    logic [S_W-1:0]   sum;
    logic             ov;
    logic [ACC_W-1:0] d_next;

    // stage 1: register full-width product and the operand controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1    <= '0;
            c1    <= '0;
            mode1 <= 1'b0;
            v1    <= 1'b0;
        end else begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                p1    <= P_W'(bus.a) * P_W'(bus.b);
                c1    <= bus.c;
                mode1 <= bus.mode;
            end
        end
    end

    // stage 2 arithmetic: accumulate mode reads acc as it stands, so back-to-back ops chain
    always_comb begin
        addend = mode1 ? acc_q : c1;
        sum    = S_W'(p1) + S_W'(addend);
        ov     = |sum[S_W-1:ACC_W];
        d_next = ((SAT != 0) && ov) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    end

    // stage 2 result registers; d holds its last value across bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            d_q         <= '0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= v1;
            ovf_q       <= v1 & ov;
            if (v1) begin
                d_q <= d_next;
            end
        end
    end

    // accumulator and sticky overflow; clr wins over a same-edge update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            ovf_sticky_q <= 1'b0;
        end else if (bus.clr) begin
            acc_q        <= '0;
            ovf_sticky_q <= 1'b0;
        end else if (v1) begin
            if (mode1) begin
                acc_q <= d_next;
            end
            if (ov) begin
                ovf_sticky_q <= 1'b1;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.d          = d_q;
    assign bus.ovf        = ovf_q;
    assign bus.ovf_sticky = ovf_sticky_q;
    assign bus.acc        = acc_q;
endmodule

// File: tb/tb_mac_pipe.sv
// tb/tb_mac_pipe.sv - scoreboard bench running wrap and saturate instances side by side
module tb_mac_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mac_pipe_if #(.A_W(8), .B_W(8), .ACC_W(16)) if0 ();
    mac_pipe_if #(.A_W(8), .B_W(8), .ACC_W(16)) if1 ();

    mac_pipe #(.A_W(8), .B_W(8), .ACC_W(16), .SAT(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    mac_pipe #(.A_W(8), .B_W(8), .ACC_W(16), .SAT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        ovf;
        logic        sticky;
        logic [15:0] acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_errors = 0;

    // model state: accumulator/sticky per instance, one pending op in stage 1
    logic [15:0] m_acc [2];
    logic        m_sticky [2];
    logic        pv;
    logic [7:0]  pa, pb;
    logic [15:0] pc;
    logic        pmode;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock of stimulus; the model resolves the edge this call ends on
    task automatic step(input logic iv, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] c, input logic md, input logic cl);
        logic [31:0] s;
        logic        ov;
        logic [15:0] dv;
        exp_t        e;
        if0.in_valid = iv; if0.a = a; if0.b = b; if0.c = c; if0.mode = md; if0.clr = cl;
        if1.in_valid = iv; if1.a = a; if1.b = b; if1.c = c; if1.mode = md; if1.clr = cl;
        for (int k = 0; k < 2; k++) begin
            if (pv) begin
                s  = {24'd0, pa} * {24'd0, pb} + {16'd0, (pmode ? m_acc[k] : pc)};
                ov = (s > 32'h0000_FFFF);
                dv = (k == 1 && ov) ? 16'hFFFF : s[15:0];
                if (pmode) m_acc[k] = dv;
                if (ov) m_sticky[k] = 1'b1;
            end
            if (cl) begin
                m_acc[k]    = 16'h0;
                m_sticky[k] = 1'b0;
            end
            if (pv) begin
                e.d = dv; e.ovf = ov; e.sticky = m_sticky[k]; e.acc = m_acc[k];
                if (k == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
        pv = iv; pa = a; pb = b; pc = c; pmode = md;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h0, 8'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        pv = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_acc[k]    = 16'h0;
            m_sticky[k] = 1'b0;
        end
    endtask

    // compare every presented result against the scoreboard, away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (if0.out_valid) begin
                if (q0.size() == 0) check("wrap_unexpected_valid", 1, 0);
                else begin
                    e = q0.pop_front();
                    check("wrap_d", if0.d, e.d);
                    check("wrap_ovf", if0.ovf, e.ovf);
                    check("wrap_sticky", if0.ovf_sticky, e.sticky);
                    check("wrap_acc", if0.acc, e.acc);
                end
            end else begin
                check("wrap_ovf_idle", if0.ovf, 0);
            end
            if (if1.out_valid) begin
                if (q1.size() == 0) check("sat_unexpected_valid", 1, 0);
                else begin
                    e = q1.pop_front();
                    check("sat_d", if1.d, e.d);
                    check("sat_ovf", if1.ovf, e.ovf);
                    check("sat_sticky", if1.ovf_sticky, e.sticky);
                    check("sat_acc", if1.acc, e.acc);
                end
            end else begin
                check("sat_ovf_idle", if1.ovf, 0);
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_wrap_valid"}, if0.out_valid, 0);
        check({tag, "_wrap_d"}, if0.d, 0);
        check({tag, "_wrap_ovf"}, if0.ovf, 0);
        check({tag, "_wrap_sticky"}, if0.ovf_sticky, 0);
        check({tag, "_wrap_acc"}, if0.acc, 0);
        check({tag, "_sat_valid"}, if1.out_valid, 0);
        check({tag, "_sat_d"}, if1.d, 0);
        check({tag, "_sat_sticky"}, if1.ovf_sticky, 0);
        check({tag, "_sat_acc"}, if1.acc, 0);
    endtask

    initial begin
        model_reset();
        if0.in_valid = 0; if0.a = 0; if0.b = 0; if0.c = 0; if0.mode = 0; if0.clr = 0;
        if1.in_valid = 0; if1.a = 0; if1.b = 0; if1.c = 0; if1.mode = 0; if1.clr = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_zero("post_reset");

        // mode 0 overflow by carry: wrap gives 0000, saturate gives FFFF
        step(1'b1, 8'h01, 8'h01, 16'hFFFF, 1'b0, 1'b0);
        check("latency_gap_wrap", if0.out_valid, 0);
        idle(2);

        // mode 0 back-to-back, clearing the sticky bit first
        step(1'b0, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b1);
        step(1'b1, 8'h01, 8'h0F, 16'h0010, 1'b0, 1'b0);
        step(1'b1, 8'h00, 8'h01, 16'hFFFF, 1'b0, 1'b0);
        idle(2);

        // mode 1 accumulate chain from 0
        step(1'b1, 8'h02, 8'h03, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 8'h04, 8'h05, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 8'h01, 8'h01, 16'h0000, 1'b1, 1'b0);
        idle(1);

        // clr lands on the (1,1) stage-2 edge while (2,2) sits in stage 1
        step(1'b1, 8'h01, 8'h01, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 8'h02, 8'h02, 16'h0000, 1'b1, 1'b1);
        idle(2);

        // build acc=FFF0, then overflow it: saturate sticks at FFFF
        step(1'b0, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b1);
        step(1'b1, 8'hFF, 8'hFF, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 8'hEF, 8'h01, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 8'h10, 8'h10, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 8'h10, 8'h01, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 8'h01, 8'h01, 16'h0000, 1'b1, 1'b0);
        idle(2);

        // product wider than ACC_W cannot occur at 8x8, so probe max product + max addend
        step(1'b1, 8'hFF, 8'hFF, 16'hFFFF, 1'b0, 1'b0);
        idle(2);

        // async reset with an op in stage 1
        step(1'b1, 8'h05, 8'h05, 16'h0001, 1'b1, 1'b0);
        if0.in_valid = 1'b0; if1.in_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("after_reset_no_valid_wrap", if0.out_valid, 0);
            check("after_reset_no_valid_sat", if1.out_valid, 0);
            idle(1);
        end
        step(1'b1, 8'h03, 8'h03, 16'h0001, 1'b0, 1'b0);
        idle(3);

        check("wrap_queue_drained", q0.size(), 0);
        check("sat_queue_drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // hard bound so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
